// File: rtl/seq_divider_16bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_16bit
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per
//            cycle, start/bsy/done handshake with divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             bsy,
    output logic             div_by_zero
);

    localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // The dividend register doubles as the quotient shift register: each step
    // shifts its MSB into the partial remainder and the new quotient bit in.
    assign w_shifted  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_dvs};
    assign w_rem_next = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            bsy         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        if (b != '0) begin
                            r_state <= c_CALC;
                            r_dvd   <= a;
                            r_dvs   <= b;
                            r_rem   <= '0;
                            r_cnt   <= c_CNT_LAST;
                            bsy     <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            // Zero divisor completes immediately without iterating.
                            r_state     <= c_DONE;
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            bsy         <= 1'b0;
                        end
                    end else begin
                        r_state <= c_IDLE;
                        done    <= 1'b0;
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state     <= c_DONE;
                        quotient    <= w_dvd_next;
                        remainder   <= w_rem_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        bsy         <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                    bsy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_16bit
// Brief    : Self-checking bench for seq_divider_16bit with expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider_16bit;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        bsy;
    logic        div_by_zero;

    int   checks;
    int   errors;
    int   bsy_cycles;
    int   done_pulses;
    int   overlap;
    exp_t exp_q[$];

    seq_divider_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .bsy         (bsy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bsy)         bsy_cycles++;
        if (done)        done_pulses++;
        if (bsy && done) overlap++;
    end

    // Drive one start pulse; optionally record the expected result.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input bit push);
        exp_t e;
        @(negedge clk); #1;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        e.q   = (tb_v == 16'd0) ? 16'hFFFF : ta / tb_v;
        e.r   = (tb_v == 16'd0) ? ta : ta % tb_v;
        e.dbz = (tb_v == 16'd0);
        if (push) exp_q.push_back(e);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Cycles counted from the cycle after the accepting edge until done is seen.
    task automatic wait_done(output bit got, output int n);
        got = 1'b0;
        n   = 0;
        while (n < 40) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({quotient, remainder} !== 32'd0) begin
            errors++;
            $display("FAIL reset_results: got q=%h r=%h, expected 0/0", quotient, remainder);
        end
        checks++;
        if ({done, bsy, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got done=%b bsy=%b dbz=%b, expected 000", done, bsy, div_by_zero);
        end
    endtask

    task automatic test_basic(input logic [15:0] ta, input logic [15:0] tb_v, input string nm);
        bit got; int n; int bs0; int dp0; exp_t e;
        bs0 = bsy_cycles;
        dp0 = done_pulses;
        start_op(ta, tb_v, 1'b1);
        wait_done(got, n);
        checks++;
        if (!got || n !== 16) begin
            errors++;
            $display("FAIL %s_latency: got=%0d after %0d cycles, expected done after 16", nm, got, n);
        end
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL %s_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     nm, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || done_pulses - dp0 !== 1 || bsy_cycles - bs0 !== 16) begin
            errors++;
            $display("FAIL %s_handshake: done=%b pulses=%0d bsy_cycles=%0d, expected 0/1/16",
                     nm, done, done_pulses - dp0, bsy_cycles - bs0);
        end
    endtask

    task automatic test_div_zero;
        bit got; int n; int bs0; exp_t e;
        bs0 = bsy_cycles;
        start_op(16'd5, 16'd0, 1'b1);
        wait_done(got, n);
        checks++;
        if (!got || n !== 0) begin
            errors++;
            $display("FAIL dz_latency: got=%0d after %0d cycles, expected done after 0", got, n);
        end
        e = exp_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bsy_cycles !== bs0 || quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_hold: bsy_cycles=%0d q=%h r=%h dbz=%b, expected 0/ffff/0005/1",
                     bsy_cycles - bs0, quotient, remainder, div_by_zero);
        end
        test_basic(16'd10, 16'd3, "dz_clear");
    endtask

    task automatic test_ignore_start;
        bit got; int n; int dp0; exp_t e;
        dp0 = done_pulses;
        start_op(16'd1000, 16'd10, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            start = 1'b1;
            a     = 16'd1 + 16'(i * 7);
            b     = 16'd1 + 16'(i);
            @(negedge clk);
        end
        #1 start = 1'b0;
        wait_done(got, n);
        e = exp_q.pop_front();
        checks++;
        if (!got || quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL ignore_result: got=%0d q=%h r=%h, expected q=%h r=%h",
                     got, quotient, remainder, e.q, e.r);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_pulses - dp0 !== 1) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d done pulses, expected 1", done_pulses - dp0);
        end
    endtask

    task automatic test_reset_mid;
        int dp0;
        start_op(16'd50000, 16'd3, 1'b0);
        repeat (7) @(negedge clk);
        #1 rst = 1'b0;
        dp0 = done_pulses;
        @(negedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({quotient, remainder} !== 32'd0 || {done, bsy, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_clear: q=%h r=%h done=%b bsy=%b dbz=%b, expected all 0",
                     quotient, remainder, done, bsy, div_by_zero);
        end
        repeat (25) @(negedge clk);
        #1;
        checks++;
        if (done_pulses !== dp0 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone: pulses=%0d bsy=%b, expected 0/0", done_pulses - dp0, bsy);
        end
        test_basic(16'd9, 16'd4, "after_reset");
    endtask

    task automatic test_back_to_back;
        bit got; int n; exp_t e; exp_t e2;
        start_op(16'd20, 16'd6, 1'b1);
        wait_done(got, n);
        e = exp_q.pop_front();
        checks++;
        if (!got || n !== 16 || quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_first: got=%0d n=%0d q=%h r=%h, expected n=16 q=%h r=%h",
                     got, n, quotient, remainder, e.q, e.r);
        end
        a      = 16'd81;
        b      = 16'd9;
        start  = 1'b1;
        e2.q   = 16'd81 / 16'd9;
        e2.r   = 16'd81 % 16'd9;
        e2.dbz = 1'b0;
        exp_q.push_back(e2);
        @(negedge clk); #1;
        start = 1'b0;
        checks++;
        if (bsy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: bsy=%b done=%b, expected 1/0", bsy, done);
        end
        wait_done(got, n);
        e = exp_q.pop_front();
        checks++;
        if (!got || n !== 16 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got=%0d n=%0d q=%h r=%h dbz=%b, expected n=16 q=%h r=%h dbz=0",
                     got, n, quotient, remainder, div_by_zero, e.q, e.r);
        end
    endtask

    task automatic test_final;
        @(negedge clk); #1;
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL bsy_done_overlap: got %0d cycles, expected 0", overlap);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected results left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        bsy_cycles  = 0;
        done_pulses = 0;
        overlap     = 0;
        test_reset();
        test_basic(16'd100, 16'd7, "basic_100_7");
        test_basic(16'hFFFF, 16'd1, "max_by_one");
        test_basic(16'd3, 16'd9, "small_by_large");
        test_basic(16'hFFFF, 16'hFFFF, "max_by_max");
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
